lenet_batch_top: RTL and testbench
==================================

# lenet_batch_top

Batch-inference controller for the LeNet accelerator, placed between the external start/result interface and the `lenet` core plus image ROM. It edge-detects a start request, then runs the core back-to-back over `cfg_count` consecutive images beginning at `cfg_first`. It offsets every core image-ROM address by the current image slot and queues each classified digit, tagged with its image index, in a result FIFO drained through a valid/ready handshake. Unlike the single-image top, it supports multiple images per run, image selection, index wrap-around and result back-pressure.

## Interface
- `WD`, 8: image pixel word width (passed through to ROM data; informational here).
- `ADDR_W`, 10: per-image ROM address width (core `aa_image` width).
- `NUM_IMAGES`, 16: image slots in ROM; `IDX_W = $clog2(NUM_IMAGES)`, min 1.
- `FIFO_DEPTH`, 4: result FIFO entries, power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level request; a 0→1 transition (vs. previous sampled value) starts a batch.
- `cfg_first` in IDX_W: first image slot, sampled on the start edge.
- `cfg_count` in IDX_W+1: images to run (0..NUM_IMAGES), sampled on the start edge.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse when a batch completes.
- `core_go` out 1: one-cycle launch pulse to the core.
- `core_ready` in 1: core done pulse; `core_digit` is valid in the same cycle.
- `core_digit` in 4: classified digit.
- `core_aa` in ADDR_W: core image-ROM address.
- `core_cena` in 1: core ROM enable.
- `rom_addr` out IDX_W+ADDR_W: `{cur_idx, core_aa}`, combinational.
- `rom_cen` out 1: equals `core_cena`, combinational.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer accepts the head.
- `res_digit` out 4: head digit.
- `res_idx` out IDX_W: head image slot.

## Operation
- Edge detect: `start_r <= start`; `go = start & ~start_r`. The edge is honoured only in IDLE; it is ignored while `busy`.
- FSM states: IDLE, LAUNCH, RUN, WAIT_SPACE.
  - IDLE: on `go` with `cfg_count==0`, pulse `done` and stay in IDLE. On `go` with a nonzero count, latch `cur_idx=cfg_first` and `remaining=cfg_count`, then go to LAUNCH.
  - LAUNCH: assert `core_go` for one cycle, then go to RUN. LAUNCH is entered only when FIFO free slots ≥1.
  - RUN: on `core_ready`, write `{core_digit, cur_idx}` into the FIFO and decrement `remaining`.
    - If `remaining` becomes 0: pulse `done` and go to IDLE.
    - Otherwise advance `cur_idx`, then go to LAUNCH if the FIFO will have a free slot next cycle, else WAIT_SPACE.
  - WAIT_SPACE: go to LAUNCH once the FIFO is not full.
- Index wrap: after `NUM_IMAGES-1`, `cur_idx` returns to 0.
- `busy` is high in every state except IDLE.
- FIFO behaviour:
  - No fall-through.
  - Pop occurs when `res_valid & res_ready`.
  - Simultaneous push and pop are legal at any occupancy, including full when a pop is present.
  - A push to a truly full FIFO is impossible by construction; an assertion checks it.
- A `core_ready` outside RUN is ignored.
- Reset clears the FSM to IDLE, empties the FIFO and zeroes `start_r`. Reset mid-batch therefore drops queued results with no `done` pulse.

## Timing
- Reset values: `busy=0`, `done=0`, `core_go=0`, `res_valid=0`, `res_digit=0`, `res_idx=0`.
- Edge in cycle E: `core_go` in E+1, `busy` high from E+1.
- `core_ready` in cycle R:
  - `res_valid` high in R+1.
  - Next `core_go` in R+1 if space is available.
  - On the last image, `done` pulses in R+1 and `busy` is low from R+1.
- `cfg_count==0` edge in E: `done` in E+1, `busy` stays 0, no `core_go`.
- Full FIFO with `res_ready` low: `core_go` is withheld. `core_go` fires the cycle after the first pop.

## Structure
- Shared package `lenet_pkg` holds `DIGIT_W=4`, the FSM state enum and the result entry struct `{digit, idx}`.
- One sub-module, `lenet_result_fifo`: synchronous FIFO parametrised on depth and entry width, with full, empty and count outputs.
- The core and ROM are instantiated one level up. This block holds control only.

## Test plan
- Single image: `cfg_first=3`, `count=1`; core returns digit 7 at R → `rom_addr` upper bits=3, `res_valid`/`res_digit=7`/`res_idx=3` at R+1, `done` at R+1.
- Batch with wrap: `NUM_IMAGES=16`, `first=14`, `count=4` → results tagged 14,15,0,1 in order, exactly 4 `core_go` pulses, one `done`.
- Back-pressure: `FIFO_DEPTH=4`, `count=6`, `res_ready=0` → exactly 4 `core_go` pulses, FSM in WAIT_SPACE. Raise `res_ready` for one cycle → next `core_go` one cycle later; all 6 results delivered in order.
- Start while `busy`, and `start` held high → no restart, no extra `core_go`. `count=0` → `done` at E+1, no `core_go`.
- Reset during RUN with 2 results queued → next cycle `busy=0`, `res_valid=0`, no `done`. A new start edge runs normally.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet batch-inference control path.
package lenet_pkg;

    // Width of a classified digit returned by the core.
    localparam int DIGIT_W   = 4;

    // Widest image index a result entry can carry (up to 256 image slots).
    localparam int IDX_W_MAX = 8;

    // Batch controller states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LAUNCH     = 2'd1,
        ST_RUN        = 2'd2,
        ST_WAIT_SPACE = 2'd3
    } batch_state_t;

    // One queued result: the classified digit tagged with its image slot.
    typedef struct packed {
        logic [DIGIT_W-1:0]   digit;
        logic [IDX_W_MAX-1:0] idx;
    } res_entry_t;

    localparam int RES_ENTRY_W = $bits(res_entry_t);

endpackage

// File: rtl/lenet_result_fifo.sv
// Synchronous result FIFO. Data written in a cycle becomes visible at the
// head on the following cycle (no fall-through). Push and pop may coincide
// at any occupancy, including full.
module lenet_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 12,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests: pop only with data present, push only into a free or freeing slot.
    always_comb begin
        do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
        do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);
    end

    // Storage array; cleared on reset so an empty head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

    lenet_result_fifo_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .full (full)
    );

endmodule

// File: rtl/lenet_result_fifo_chk.sv
// Checker for the result FIFO: a push must never land on a full FIFO
// unless a pop frees a slot in the same cycle.
module lenet_result_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);

    property p_no_overflow;
        @(posedge clk) disable iff (rst) !(push && full && !pop);
    endproperty

    a_no_overflow: assert property (p_no_overflow)
        else $error("lenet_result_fifo: push into a full FIFO");

endmodule

// File: rtl/lenet_batch_top.sv
// Batch-inference controller: runs the LeNet core over a run of consecutive
// image slots, offsets core ROM addresses by the current slot and queues
// each classified digit with its slot index for a valid/ready consumer.
module lenet_batch_top
    import lenet_pkg::*;
#(
    parameter  int WD         = 8,
    parameter  int ADDR_W     = 10,
    parameter  int NUM_IMAGES = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDX_W-1:0]        cfg_first,
    input  logic [IDX_W:0]          cfg_count,
    output logic                    busy,
    output logic                    done,
    output logic                    core_go,
    input  logic                    core_ready,
    input  logic [DIGIT_W-1:0]      core_digit,
    input  logic [ADDR_W-1:0]       core_aa,
    input  logic                    core_cena,
    output logic [IDX_W+ADDR_W-1:0] rom_addr,
    output logic                    rom_cen,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DIGIT_W-1:0]      res_digit,
    output logic [IDX_W-1:0]        res_idx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_IMAGES - 1);
    localparam logic [IDX_W:0]   ONE_CNT   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    // Reject parameter sets the FIFO pointers and result entry cannot represent.
    if (WD < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IDX_W > IDX_W_MAX) begin : g_param_check
        $error("lenet_batch_top: unsupported parameter set");
    end

    batch_state_t     state_r;
    batch_state_t     state_nxt_s;
    logic             start_r;
    logic             go_s;
    logic [IDX_W-1:0] cur_idx_r;
    logic [IDX_W-1:0] cur_idx_nxt_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic [IDX_W:0]   remaining_r;
    logic [IDX_W:0]   remaining_nxt_s;
    logic             done_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             core_go_r;

    logic             push_s;
    logic             pop_s;
    logic             space_now_s;
    logic             space_after_push_s;
    logic [CNT_W:0]   occ_after_push_s;
    res_entry_t       push_entry_s;
    res_entry_t       head_entry_s;
    logic [RES_ENTRY_W-1:0] fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    // Start edge, FIFO space look-ahead and result entry packing.
    always_comb begin
        go_s        = start & ~start_r;
        pop_s       = ~fifo_empty_s & res_ready;
        // A slot is free next cycle when nothing is pushed now.
        space_now_s = ~fifo_full_s | pop_s;
        // Occupancy after this cycle if a result is pushed now.
        occ_after_push_s   = {1'b0, fifo_count_s} + (CNT_W + 1)'(1'b1) - (CNT_W + 1)'(pop_s);
        space_after_push_s = (occ_after_push_s < DEPTH_EXT);
        if (cur_idx_r == LAST_IDX) begin
            idx_inc_s = {IDX_W{1'b0}};
        end else begin
            idx_inc_s = cur_idx_r + IDX_W'(1'b1);
        end
        push_entry_s.digit = core_digit;
        push_entry_s.idx   = IDX_W_MAX'(cur_idx_r);
    end

    // Next-state logic of the batch sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        cur_idx_nxt_s   = cur_idx_r;
        remaining_nxt_s = remaining_r;
        done_nxt_s      = 1'b0;
        push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    if (cfg_count == {(IDX_W + 1){1'b0}}) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        cur_idx_nxt_s   = cfg_first;
                        remaining_nxt_s = cfg_count;
                        // Results of an earlier batch may still fill the FIFO.
                        state_nxt_s     = space_now_s ? ST_LAUNCH : ST_WAIT_SPACE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (core_ready) begin
                    push_s          = 1'b1;
                    remaining_nxt_s = remaining_r - ONE_CNT;
                    if (remaining_r == ONE_CNT) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cur_idx_nxt_s = idx_inc_s;
                        state_nxt_s   = space_after_push_s ? ST_LAUNCH : ST_WAIT_SPACE;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_SPACE: begin
                if (space_now_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_WAIT_SPACE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, batch bookkeeping and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            start_r     <= 1'b0;
            cur_idx_r   <= {IDX_W{1'b0}};
            remaining_r <= {(IDX_W + 1){1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            core_go_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            start_r     <= start;
            cur_idx_r   <= cur_idx_nxt_s;
            remaining_r <= remaining_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= done_nxt_s;
            core_go_r   <= (state_nxt_s == ST_LAUNCH);
        end
    end

    lenet_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RES_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (push_entry_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign head_entry_s = res_entry_t'(fifo_dout_s);

    assign busy      = busy_r;
    assign done      = done_r;
    assign core_go   = core_go_r;
    assign rom_addr  = {cur_idx_r, core_aa};
    assign rom_cen   = core_cena;
    assign res_valid = ~fifo_empty_s;
    assign res_digit = head_entry_s.digit;
    assign res_idx   = IDX_W'(head_entry_s.idx);

endmodule

// File: tb/tb_lenet_batch_top.sv
// Self-checking bench for lenet_batch_top: a transaction-level model of the
// batch (images left, outstanding core job, expected result queue) predicts
// every output each cycle; directed scenarios add hand-computed pins.
module tb_lenet_batch_top;

    localparam int ADDR_W     = 10;
    localparam int NUM_IMAGES = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, start, busy, done, core_go, core_ready, core_cena;
    logic                    rom_cen, res_valid, res_ready;
    logic [IDX_W-1:0]        cfg_first, res_idx;
    logic [IDX_W:0]          cfg_count;
    logic [3:0]              core_digit, res_digit;
    logic [ADDR_W-1:0]       core_aa;
    logic [IDX_W+ADDR_W-1:0] rom_addr;

    lenet_batch_top #(
        .WD(8), .ADDR_W(ADDR_W), .NUM_IMAGES(NUM_IMAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_count(cfg_count),
        .busy(busy), .done(done), .core_go(core_go), .core_ready(core_ready),
        .core_digit(core_digit), .core_aa(core_aa), .core_cena(core_cena),
        .rom_addr(rom_addr), .rom_cen(rom_cen), .res_valid(res_valid),
        .res_ready(res_ready), .res_digit(res_digit), .res_idx(res_idx)
    );

    typedef struct { int digit; int idx; } exp_t;

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    // stimulus controls
    bit drv_rst = 1'b1, drv_start = 1'b0, drv_res_ready = 1'b0, stray_en = 1'b0, chk_en = 1'b0;
    int drv_first = 0, drv_count = 0, force_lat = 0, force_digit = -1;

    // bench core
    int   core_lat = 0;
    bit   cr_v;
    int   cd_v;

    // behavioural model
    exp_t mq[$];
    bit   m_busy = 1'b0, m_job = 1'b0, m_wait = 1'b0, m_prev = 1'b0, e_done = 1'b0, e_go = 1'b0;
    int   m_left = 0, m_idx = 0;

    // observation
    int go_cnt = 0, done_cnt = 0;
    int obs_idx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model prediction for this cycle.
    task automatic check_outputs();
        chk("busy", busy, 32'(m_busy));
        chk("done", done, 32'(e_done));
        chk("core_go", core_go, 32'(e_go));
        chk("res_valid", res_valid, 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("res_digit", res_digit, mq[0].digit);
            chk("res_idx", res_idx, mq[0].idx);
        end
    endtask

    // Apply the effect of this cycle's inputs to the model at the coming edge.
    task automatic model_advance();
        bit pop, push, want;
        e_done = 1'b0;
        e_go   = 1'b0;
        if (drv_rst) begin
            mq.delete();
            m_busy = 1'b0; m_job = 1'b0; m_wait = 1'b0; m_prev = 1'b0;
            m_left = 0; m_idx = 0;
            return;
        end
        want = 1'b0;
        pop  = (mq.size() > 0) && drv_res_ready;
        push = m_busy && m_job && cr_v;
        if (pop) void'(mq.pop_front());
        if (!m_busy) begin
            if (drv_start && !m_prev) begin
                if (drv_count == 0) e_done = 1'b1;
                else begin
                    m_busy = 1'b1; m_idx = drv_first; m_left = drv_count; want = 1'b1;
                end
            end
        end else if (push) begin
            mq.push_back('{digit: cd_v, idx: m_idx});
            m_job = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; e_done = 1'b1;
            end else begin
                m_idx = (m_idx + 1) % NUM_IMAGES; want = 1'b1;
            end
        end else if (m_wait) begin
            want = 1'b1;
        end
        if (want) begin
            if (mq.size() < FIFO_DEPTH) begin
                e_go = 1'b1; m_job = 1'b1; m_wait = 1'b0;
            end else begin
                m_wait = 1'b1;
            end
        end
        m_prev = drv_start;
    endtask

    // One clock cycle: check, emulate the core, drive inputs, advance the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check_outputs();
            go_cnt   += int'(core_go);
            done_cnt += int'(done);
        end
        cr_v = 1'b0;
        if (drv_rst) core_lat = 0;
        else if (core_go === 1'b1) core_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
        else if (core_lat > 0) begin
            core_lat--;
            if (core_lat == 0) cr_v = 1'b1;
        end
        if (!cr_v && stray_en && !m_job && $urandom_range(0, 7) == 0) cr_v = 1'b1;
        cd_v = (force_digit >= 0) ? force_digit : int'($urandom_range(0, 15));
        rst        = drv_rst;
        start      = drv_start;
        cfg_first  = IDX_W'(drv_first);
        cfg_count  = (IDX_W + 1)'(drv_count);
        res_ready  = drv_res_ready;
        core_ready = cr_v;
        core_digit = 4'(cd_v);
        core_aa    = ADDR_W'($urandom);
        core_cena  = 1'($urandom);
        if (chk_en && res_valid === 1'b1 && drv_res_ready) obs_idx.push_back(int'(res_idx));
        #1;
        if (chk_en) begin
            chk("rom_cen", rom_cen, core_cena);
            if (m_busy) chk("rom_addr", rom_addr, {IDX_W'(m_idx), core_aa});
        end
        model_advance();
    endtask

    task automatic reset_dut();
        drv_rst = 1'b1; drv_start = 1'b0;
        tick(); tick();
        drv_rst = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        for (int c = 0; c < budget && m_busy; c++) tick();
        chk("batch_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic drain();
        drv_res_ready = 1'b1; drv_start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic clear_obs();
        go_cnt = 0; done_cnt = 0; obs_idx.delete();
    endtask

    initial begin
        int exp_wrap[4];
        rst = 1'b1; start = 1'b0; cfg_first = '0; cfg_count = '0; core_ready = 1'b0;
        core_digit = '0; core_aa = '0; core_cena = 1'b0; res_ready = 1'b0;

        // reset and reset values
        tick(); tick();
        chk_en = 1'b1;
        reset_dut();
        tick();
        chk("rst_busy", busy, 32'd0);
        chk("rst_res_valid", res_valid, 32'd0);
        chk("rst_res_digit", res_digit, 32'd0);
        chk("rst_res_idx", res_idx, 32'd0);

        // single image: first=3, digit 7, core answers 2 cycles after core_go
        force_lat = 2; force_digit = 7; drv_res_ready = 1'b0;
        drv_first = 3; drv_count = 1; drv_start = 1'b1;
        tick();                                   // E
        drv_start = 1'b0;
        tick();                                   // E+1
        chk("single_go_e1", core_go, 32'd1);
        chk("single_busy_e1", busy, 32'd1);
        chk("single_rom_hi", rom_addr[ADDR_W +: IDX_W], 32'd3);
        tick(); tick();                           // E+2, R=E+3
        tick();                                   // R+1
        chk("single_valid", res_valid, 32'd1);
        chk("single_digit", res_digit, 32'd7);
        chk("single_idx", res_idx, 32'd3);
        chk("single_done", done, 32'd1);
        chk("single_busy_off", busy, 32'd0);
        tick();
        chk("single_done_once", done, 32'd0);
        drain();

        // count=0: done at E+1, no launch
        drv_count = 0; drv_start = 1'b1;
        tick();                                   // E
        drv_start = 1'b0;
        tick();                                   // E+1
        chk("zero_done", done, 32'd1);
        chk("zero_busy", busy, 32'd0);
        chk("zero_go", core_go, 32'd0);
        tick();
        chk("zero_done_once", done, 32'd0);

        // wrap-around batch with start held high throughout
        clear_obs();
        force_lat = 0; force_digit = -1; drv_res_ready = 1'b1;
        drv_first = 14; drv_count = 4; drv_start = 1'b1;
        tick();
        run_until_idle(200);
        for (int c = 0; c < 6; c++) tick();
        exp_wrap = '{14, 15, 0, 1};
        chk("wrap_n", obs_idx.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("wrap_idx", (i < obs_idx.size()) ? obs_idx[i] : -1, exp_wrap[i]);
        chk("wrap_go_cnt", go_cnt, 32'd4);
        chk("wrap_done_cnt", done_cnt, 32'd1);
        drv_start = 1'b0;
        drain();

        // back-pressure: 6 images, consumer stalled
        clear_obs();
        force_lat = 1; drv_res_ready = 1'b0;
        drv_first = 5; drv_count = 6; drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            drv_start = (c % 7 == 3);             // edges while busy are ignored
            tick();
        end
        drv_start = 1'b0;
        chk("bp_go_cnt", go_cnt, 32'd4);
        chk("bp_busy", busy, 32'd1);
        chk("bp_valid", res_valid, 32'd1);
        drv_res_ready = 1'b1;
        tick();                                   // P: single pop
        drv_res_ready = 1'b0;
        tick();                                   // P+1
        chk("bp_go_after_pop", core_go, 32'd1);
        drv_res_ready = 1'b1;
        run_until_idle(200);
        drain();
        chk("bp_n", obs_idx.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("bp_idx", (i < obs_idx.size()) ? obs_idx[i] : -1, 5 + i);
        chk("bp_go_total", go_cnt, 32'd6);
        chk("bp_done_cnt", done_cnt, 32'd1);

        // reset mid-run with two results queued
        drv_res_ready = 1'b0; force_lat = 1;
        drv_first = 2; drv_count = 4; drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
        for (int c = 0; c < 60 && !(mq.size() == 2 && m_job); c++) tick();
        chk("rstrun_setup", mq.size(), 32'd2);
        drv_rst = 1'b1;
        tick();
        drv_rst = 1'b0;
        tick();
        chk("rstrun_busy", busy, 32'd0);
        chk("rstrun_valid", res_valid, 32'd0);
        chk("rstrun_done", done, 32'd0);
        clear_obs();
        drv_res_ready = 1'b1; drv_first = 9; drv_count = 2; drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
        run_until_idle(100);
        drain();
        chk("rstrun_go_cnt", go_cnt, 32'd2);
        chk("rstrun_done_cnt", done_cnt, 32'd1);
        chk("rstrun_n", obs_idx.size(), 32'd2);

        // randomized batches against the model
        force_lat = 0; force_digit = -1; stray_en = 1'b1;
        for (int b = 0; b < 25; b++) begin
            int rr;
            rr = $urandom_range(0, 3);
            drv_first = $urandom_range(0, NUM_IMAGES - 1);
            drv_count = $urandom_range(0, NUM_IMAGES);
            drv_start = 1'b1;
            tick();
            for (int c = 0; c < 600 && m_busy; c++) begin
                drv_start     = ($urandom_range(0, 3) == 0);
                drv_res_ready = ($urandom_range(0, 3) >= rr);
                tick();
            end
            chk("rand_timeout", 32'(m_busy), 32'd0);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
